usb_rx_packet_ctrl: RTL and testbench
=====================================

Name: usb_rx_packet_ctrl

Overview:
- Sequencing FSM for the USB receive datapath (NRZI decoder, bit-stuff/timing strobe, EOP detector, field shift registers).
- Tracks bit position within a packet and steers each decoded bit to the correct field register: SYNC, PID, CRC5, CRC16 or DATA.
- Validates SYNC and PID, selects the field sequence from the PID class, and reports packet completion or error to the downstream consumer.

Parameters:
- SYNC_PATTERN, 8'b10000000, required SYNC byte value.
- TOKEN_PID, 4'b0110, PID[3:0] code for token packets (SYNC, PID, CRC5).
- DATA_PID, 4'b1100, PID[3:0] code for data packets (SYNC, PID, CRC16, 64-bit DATA).
- HSHAKE_PID, 4'b1101, PID[3:0] code for handshake packets (SYNC, PID).
- DATA_BITS, 64, DATA field length in bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- shift_enable  in  1  one-cycle strobe: a decoded bit is valid this cycle
- d_edge  in  1  one-cycle pulse on a line transition
- eop  in  1  level: SE0 (EOP) is present on the line
- rcv_sync  in  8  SYNC shift-register contents from the datapath
- rcv_pid  in  8  PID shift-register contents from the datapath
- sync_shift  out  1  SYNC register shift enable
- pid_shift  out  1  PID register shift enable
- crc5_shift  out  1  CRC5 register shift enable
- crc16_shift  out  1  CRC16 register shift enable
- data_shift  out  1  DATA register shift enable
- rcving  out  1  high from packet start until return to IDLE
- packet_done  out  1  one-cycle pulse on a valid EOP
- rcv_error  out  1  sticky error flag
- pkt_type  out  2  packet class: 00 none, 01 token, 10 data, 11 handshake

Behaviour:
- Reset: state IDLE, bit counter 0, pkt_type 00, rcv_error 0. All shift enables, rcving and packet_done are 0.
- Shift enables: each xxx_shift = shift_enable AND (state == that field state). They are combinational, so the datapath shifts on the same edge.
- Bit counter: 7 bits. Increments on shift_enable in a field state. Clears on every field transition.
- Field order: bits are shifted MSB-first.
- States and transitions:
  - IDLE: on d_edge, go to SYNC; clear rcv_error and pkt_type; set rcving.
  - SYNC: after 8 shifts, go to CHK_SYNC.
  - CHK_SYNC (1 cycle): if rcv_sync == SYNC_PATTERN go to PID, else go to ERR.
  - PID: after 8 shifts, go to CHK_PID.
  - CHK_PID (1 cycle):
    - If rcv_pid[7:4] != ~rcv_pid[3:0], go to ERR.
    - TOKEN_PID: go to CRC5, pkt_type = 01.
    - DATA_PID: go to CRC16, pkt_type = 10.
    - HSHAKE_PID: go to WAIT_EOP, pkt_type = 11.
    - Any other code: go to ERR.
  - CRC5: after 5 shifts, go to WAIT_EOP.
  - CRC16: after 16 shifts, go to DATA.
  - DATA: after DATA_BITS shifts, go to WAIT_EOP.
  - WAIT_EOP: eop goes to DONE; shift_enable without eop goes to ERR.
  - DONE: packet_done = 1 for this one cycle only; then go to EOP_IDLE.
  - EOP_IDLE: when eop deasserts, go to IDLE and clear rcving.
  - ERR: rcv_error = 1; when eop deasserts after having been seen, go to IDLE. rcv_error stays high until the next packet start.
- EOP asserted in SYNC, PID, CRC5, CRC16 or DATA (field incomplete): go to ERR.
- Simultaneous eop and shift_enable: eop has priority and the bit is not shifted.
- d_edge outside IDLE is ignored.
- Reset mid-packet: immediate return to IDLE, all outputs at reset values.

Test Plan:
- Token: SYNC 10000000, PID 10010110, CRC5 10000, EOP -> crc5_shift pulses exactly 5 times, pkt_type = 01, packet_done one pulse, rcv_error = 0.
- Data: SYNC, PID 00111100, CRC16 F0F0, 64 data bits, EOP -> crc16_shift 16 pulses, data_shift 64 pulses, pkt_type = 10, packet_done pulses.
- Handshake: SYNC, PID 00101101, EOP -> no CRC or DATA shifts, pkt_type = 11, packet_done pulses.
- Bad PID 10010111 (nibbles not complementary) -> ERR, rcv_error = 1, no packet_done, returns to IDLE after EOP; next valid packet clears rcv_error.
- Early EOP after 30 data bits -> rcv_error = 1, data_shift count 30, no packet_done. Bad SYNC 11000000 -> rcv_error = 1.
- rst asserted during DATA bit 20 -> all outputs 0 immediately; a following token packet completes normally.

Source files
------------

// File: rtl/usb_rx_packet_ctrl.sv
// Receive-side packet sequencer for a USB full-speed datapath: walks SYNC, PID
// and the PID-selected fields, steering each decoded bit into its register.
module usb_rx_packet_ctrl #(
  parameter logic [7:0] SYNC_PATTERN = 8'b10000000,
  parameter logic [3:0] TOKEN_PID    = 4'b0110,
  parameter logic [3:0] DATA_PID     = 4'b1100,
  parameter logic [3:0] HSHAKE_PID   = 4'b1101,
  parameter int         DATA_BITS    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_enable,
  input  logic       d_edge,
  input  logic       eop,
  input  logic [7:0] rcv_sync,
  input  logic [7:0] rcv_pid,
  output logic       sync_shift,
  output logic       pid_shift,
  output logic       crc5_shift,
  output logic       crc16_shift,
  output logic       data_shift,
  output logic       rcving,
  output logic       packet_done,
  output logic       rcv_error,
  output logic [1:0] pkt_type
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC,
    S_CHK_SYNC,
    S_PID,
    S_CHK_PID,
    S_CRC5,
    S_CRC16,
    S_DATA,
    S_WAIT_EOP,
    S_DONE,
    S_EOP_IDLE,
    S_ERR
  } state_t;

  localparam logic [6:0] DATA_LAST = 7'(DATA_BITS - 1);

  state_t     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [1:0] pkt_type_q, pkt_type_d;
  logic       rcv_error_q, rcv_error_d;
  logic       rcving_q, rcving_d;
  logic       eop_seen_q, eop_seen_d;

  logic       field_state;
  logic [6:0] field_last;
  state_t     field_next;
  logic       bit_take;

  // Per-field length and successor; only meaningful while field_state is high.
  always_comb begin
    field_state = 1'b0;
    field_last  = 7'd0;
    field_next  = S_IDLE;
    case (state_q)
      S_SYNC:  begin field_state = 1'b1; field_last = 7'd7;  field_next = S_CHK_SYNC; end
      S_PID:   begin field_state = 1'b1; field_last = 7'd7;  field_next = S_CHK_PID;  end
      S_CRC5:  begin field_state = 1'b1; field_last = 7'd4;  field_next = S_WAIT_EOP; end
      S_CRC16: begin field_state = 1'b1; field_last = 7'd15; field_next = S_DATA;     end
      S_DATA:  begin field_state = 1'b1; field_last = DATA_LAST; field_next = S_WAIT_EOP; end
      default: ;
    endcase
  end

  // EOP wins over a coincident bit strobe, so that bit is never shifted.
  assign bit_take = shift_enable & ~eop & field_state;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pkt_type_d  = pkt_type_q;
    rcv_error_d = rcv_error_q;
    rcving_d    = rcving_q;
    eop_seen_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (d_edge) begin
          state_d     = S_SYNC;
          cnt_d       = 7'd0;
          rcv_error_d = 1'b0;
          pkt_type_d  = 2'b00;
          rcving_d    = 1'b1;
        end
      end
      S_SYNC, S_PID, S_CRC5, S_CRC16, S_DATA: begin
        if (eop) begin
          state_d = S_ERR;
          cnt_d   = 7'd0;
        end else if (shift_enable) begin
          if (cnt_q == field_last) begin
            state_d = field_next;
            cnt_d   = 7'd0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      S_CHK_SYNC: begin
        state_d = (rcv_sync == SYNC_PATTERN) ? S_PID : S_ERR;
      end
      S_CHK_PID: begin
        if (rcv_pid[7:4] != ~rcv_pid[3:0]) begin
          state_d = S_ERR;
        end else if (rcv_pid[3:0] == TOKEN_PID) begin
          state_d    = S_CRC5;
          pkt_type_d = 2'b01;
        end else if (rcv_pid[3:0] == DATA_PID) begin
          state_d    = S_CRC16;
          pkt_type_d = 2'b10;
        end else if (rcv_pid[3:0] == HSHAKE_PID) begin
          state_d    = S_WAIT_EOP;
          pkt_type_d = 2'b11;
        end else begin
          state_d = S_ERR;
        end
      end
      S_WAIT_EOP: begin
        if (eop) begin
          state_d = S_DONE;
        end else if (shift_enable) begin
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        state_d = S_EOP_IDLE;
      end
      S_EOP_IDLE: begin
        if (!eop) begin
          state_d  = S_IDLE;
          rcving_d = 1'b0;
        end
      end
      S_ERR: begin
        eop_seen_d = eop_seen_q | eop;
        if (eop_seen_q && !eop) begin
          state_d    = S_IDLE;
          rcving_d   = 1'b0;
          eop_seen_d = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        rcving_d = 1'b0;
      end
    endcase

    // An EOP that causes the error already counts as seen, so a one-cycle SE0 still recovers.
    if (state_d == S_ERR) begin
      rcv_error_d = 1'b1;
      if (state_q != S_ERR) begin
        eop_seen_d = eop;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 7'd0;
      pkt_type_q  <= 2'b00;
      rcv_error_q <= 1'b0;
      rcving_q    <= 1'b0;
      eop_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pkt_type_q  <= pkt_type_d;
      rcv_error_q <= rcv_error_d;
      rcving_q    <= rcving_d;
      eop_seen_q  <= eop_seen_d;
    end
  end

  assign sync_shift  = bit_take & (state_q == S_SYNC);
  assign pid_shift   = bit_take & (state_q == S_PID);
  assign crc5_shift  = bit_take & (state_q == S_CRC5);
  assign crc16_shift = bit_take & (state_q == S_CRC16);
  assign data_shift  = bit_take & (state_q == S_DATA);
  assign packet_done = (state_q == S_DONE);
  assign rcving      = rcving_q;
  assign rcv_error   = rcv_error_q;
  assign pkt_type    = pkt_type_q;

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Directed bench for usb_rx_packet_ctrl: the bench plays the datapath (SYNC/PID
// shift registers) and counts every shift/done pulse per packet against a queue.
module tb_usb_rx_packet_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       shift_enable;
  logic       d_edge;
  logic       eop;
  logic [7:0] rcv_sync;
  logic [7:0] rcv_pid;
  logic       sync_shift, pid_shift, crc5_shift, crc16_shift, data_shift;
  logic       rcving, packet_done, rcv_error;
  logic [1:0] pkt_type;
  logic       cur_bit;

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  int n_sync = 0, n_pid = 0, n_crc5 = 0, n_crc16 = 0, n_data = 0, n_done = 0;
  int b_sync, b_pid, b_crc5, b_crc16, b_data, b_done;

  usb_rx_packet_ctrl dut (
    .clk(clk), .rst(rst), .shift_enable(shift_enable), .d_edge(d_edge), .eop(eop),
    .rcv_sync(rcv_sync), .rcv_pid(rcv_pid),
    .sync_shift(sync_shift), .pid_shift(pid_shift), .crc5_shift(crc5_shift),
    .crc16_shift(crc16_shift), .data_shift(data_shift), .rcving(rcving),
    .packet_done(packet_done), .rcv_error(rcv_error), .pkt_type(pkt_type)
  );

  // clock / reset
  always #5 clk = ~clk;

  // datapath model: MSB-first shift registers fed by the DUT enables
  always @(posedge clk) begin
    if (sync_shift) rcv_sync <= {rcv_sync[6:0], cur_bit};
    if (pid_shift)  rcv_pid  <= {rcv_pid[6:0], cur_bit};
  end

  // pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (sync_shift)  n_sync  <= n_sync + 1;
    if (pid_shift)   n_pid   <= n_pid + 1;
    if (crc5_shift)  n_crc5  <= n_crc5 + 1;
    if (crc16_shift) n_crc16 <= n_crc16 + 1;
    if (data_shift)  n_data  <= n_data + 1;
    if (packet_done) n_done  <= n_done + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_bit(input logic b);
    cur_bit      = b;
    shift_enable = 1'b1;
    @(posedge clk); #1;
    shift_enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_field(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic start_pkt;
    b_sync = n_sync; b_pid = n_pid; b_crc5 = n_crc5;
    b_crc16 = n_crc16; b_data = n_data; b_done = n_done;
    d_edge = 1'b1;
    @(posedge clk); #1;
    d_edge = 1'b0;
    check("start_rcving", 16'(rcving), 16'd1);
    check("start_err_clr", 16'(rcv_error), 16'd0);
  endtask

  task automatic send_eop;
    eop = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    eop = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic expect_pkt(input int s, input int p, input int c5, input int c16,
                            input int d, input int dn, input int ty, input int er);
    exp_q.push_back(16'(s));  exp_q.push_back(16'(p));
    exp_q.push_back(16'(c5)); exp_q.push_back(16'(c16));
    exp_q.push_back(16'(d));  exp_q.push_back(16'(dn));
    exp_q.push_back(16'(ty)); exp_q.push_back(16'(er));
  endtask

  // scoreboard pop: waits (bounded) for the packet to finish, then compares
  task automatic check_pkt(input string name);
    int n = 0;
    while (rcving !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
    check({name, "_idle"}, 16'(rcving), 16'd0);
    check({name, "_sync_cnt"},  16'(n_sync - b_sync),   exp_q.pop_front());
    check({name, "_pid_cnt"},   16'(n_pid - b_pid),     exp_q.pop_front());
    check({name, "_crc5_cnt"},  16'(n_crc5 - b_crc5),   exp_q.pop_front());
    check({name, "_crc16_cnt"}, 16'(n_crc16 - b_crc16), exp_q.pop_front());
    check({name, "_data_cnt"},  16'(n_data - b_data),   exp_q.pop_front());
    check({name, "_done_cnt"},  16'(n_done - b_done),   exp_q.pop_front());
    check({name, "_pkt_type"},  16'(pkt_type),          exp_q.pop_front());
    check({name, "_rcv_error"}, 16'(rcv_error),         exp_q.pop_front());
  endtask

  task automatic token_pkt(input string name);
    expect_pkt(8, 8, 5, 0, 0, 1, 1, 0);
    start_pkt();
    send_field(64'h80, 8);
    send_field(64'b10010110, 8);
    send_field(64'b10000, 5);
    send_eop();
    check_pkt(name);
  endtask

  function automatic logic [9:0] all_outs();
    return {sync_shift, pid_shift, crc5_shift, crc16_shift, data_shift,
            rcving, packet_done, rcv_error, pkt_type};
  endfunction

  initial begin
    logic [63:0] payload;
    rst = 1'b1; shift_enable = 1'b0; d_edge = 1'b0; eop = 1'b0; cur_bit = 1'b0;
    rcv_sync = 8'h00; rcv_pid = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 16'(all_outs()), 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    token_pkt("token");

    // data packet, with a stray d_edge mid-packet that must be ignored
    payload = {$urandom, $urandom};
    expect_pkt(8, 8, 0, 16, 64, 1, 2, 0);
    start_pkt();
    send_field(64'h80, 8);
    d_edge = 1'b1; @(posedge clk); #1; d_edge = 1'b0;
    send_field(64'b00111100, 8);
    send_field(64'hF0F0, 16);
    send_field(payload, 64);
    send_eop();
    check_pkt("data");

    expect_pkt(8, 8, 0, 0, 0, 1, 3, 0);
    start_pkt();
    send_field(64'h80, 8);
    send_field(64'b00101101, 8);
    send_eop();
    check_pkt("hshake");

    expect_pkt(8, 8, 0, 0, 0, 0, 0, 1);
    start_pkt();
    send_field(64'h80, 8);
    send_field(64'b10010111, 8);
    @(posedge clk); #1;
    send_eop();
    check_pkt("bad_pid");

    token_pkt("token_after_err");

    expect_pkt(8, 8, 0, 16, 30, 0, 2, 1);
    start_pkt();
    send_field(64'h80, 8);
    send_field(64'b00111100, 8);
    send_field(64'hF0F0, 16);
    send_field(64'(($urandom & 32'h3FFF_FFFF)), 30);
    send_eop();
    check_pkt("early_eop");

    expect_pkt(8, 0, 0, 0, 0, 0, 0, 1);
    start_pkt();
    send_field(64'hC0, 8);
    send_eop();
    check_pkt("bad_sync");

    // reset while a data bit is being presented
    start_pkt();
    send_field(64'h80, 8);
    send_field(64'b00111100, 8);
    send_field(64'hF0F0, 16);
    send_field(64'h000A_5A5A, 20);
    check("mid_data_cnt", 16'(n_data - b_data), 16'd20);
    cur_bit = 1'b1;
    shift_enable = 1'b1;
    #1;
    check("mid_data_shift", 16'(data_shift), 16'd1);
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", 16'(all_outs()), 16'd0);
    shift_enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    token_pkt("token_after_rst");

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
